// File: rtl/interlaken_seq_pkg.sv
// Shared encodings for the Interlaken latency-bench test sequencer:
// state codes, failure codes and progress-message bit positions.
package interlaken_seq_pkg;

  typedef enum logic [3:0] {
    S_RESET_HOLD     = 4'd0,
    S_GT_LOCK_WAIT   = 4'd1,
    S_RX_ALIGN_WAIT  = 4'd2,
    S_PACKET_SEND    = 4'd3,
    S_PACKET_RECEIVE = 4'd4,
    S_IDLE_WAIT      = 4'd5,
    S_RESTART        = 4'd6,
    S_BUSY_WAIT      = 4'd7,
    S_DONE           = 4'd8,
    S_FAIL           = 4'd9
  } seq_state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_TIMEOUT = 3'd1;
  localparam logic [2:0] FC_TX_FAIL = 3'd2;
  localparam logic [2:0] FC_RX_FAIL = 3'd3;

  localparam int MSG_RST_DONE = 0;
  localparam int MSG_GT_LOCK  = 1;
  localparam int MSG_RX_ALIGN = 2;
  localparam int MSG_TX_DONE  = 3;
  localparam int MSG_RX_DONE  = 4;
  localparam int MSG_IDLE     = 5;
  localparam int MSG_RESTART  = 6;
  localparam int MSG_BUSY     = 7;
  localparam int MSG_DONE     = 8;

  function automatic logic is_timed(seq_state_e s);
    return s inside {S_GT_LOCK_WAIT, S_RX_ALIGN_WAIT,
                     S_PACKET_SEND, S_PACKET_RECEIVE,
                     S_IDLE_WAIT, S_BUSY_WAIT};
  endfunction

  function automatic logic is_traffic(seq_state_e s);
    return s inside {S_PACKET_SEND, S_PACKET_RECEIVE,
                     S_IDLE_WAIT};
  endfunction

endpackage

// File: rtl/interlaken_seq_timer.sv
// Per-state watchdog: cleared on every state change, counts while
// enabled and flags the last allowed cycle of a wait state.
module interlaken_seq_timer #(
  parameter int TO_W           = 20,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic init_clk,
  input  logic clk_reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge init_clk) begin
    if (clk_reset || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/interlaken_test_sequencer.sv
// Bring-up, packet-run and verdict sequencer for the Interlaken
// latency bench, with per-run send-to-receive latency capture.
module interlaken_test_sequencer
  import interlaken_seq_pkg::*;
#(
  parameter int NUM_CORES       = 2,
  parameter int NUM_RUNS        = 2,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int TO_W            = 20,
  parameter int LAT_W           = 24
) (
  input  logic                 init_clk,
  input  logic                 clk_reset,
  input  logic [NUM_CORES-1:0] gt_locked,
  input  logic [NUM_CORES-1:0] rx_aligned,
  input  logic [NUM_CORES-1:0] tx_done,
  input  logic [NUM_CORES-1:0] tx_busy,
  input  logic [NUM_CORES-1:0] rx_done,
  input  logic [NUM_CORES-1:0] rx_busy,
  input  logic [NUM_CORES-1:0] tx_fail,
  input  logic [NUM_CORES-1:0] rx_failed,
  output logic                 sys_reset,
  output logic                 lbus_tx_rx_restart_in,
  output logic                 s_axi_pm_tick,
  output logic [3:0]           state,
  output logic [7:0]           run_count,
  output logic [8:0]           msg,
  output logic [LAT_W-1:0]     last_latency,
  output logic [LAT_W-1:0]     max_latency,
  output logic                 test_done,
  output logic                 test_pass,
  output logic [2:0]           fail_code
);

  seq_state_e       state_q, state_d;
  logic [2:0]       fail_d;
  logic [8:0]       msg_set;
  logic [7:0]       hold_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             to_expired;
  logic             rx_exit, lat_clr;

  assign state   = state_q;
  assign rx_exit = (state_q == S_PACKET_RECEIVE) &&
                   (state_d == S_IDLE_WAIT);
  assign lat_clr = (state_q != S_PACKET_SEND) &&
                   (state_d == S_PACKET_SEND);

  interlaken_seq_timer #(
    .TO_W          (TO_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .init_clk (init_clk),
    .clk_reset(clk_reset),
    .clear    (state_d != state_q),
    .en       (is_timed(state_q)),
    .expired  (to_expired)
  );

  always_comb begin
    state_d = state_q;
    fail_d  = fail_code;
    msg_set = '0;
    unique case (state_q)
      S_RESET_HOLD:
        if (hold_cnt == 8'(RST_HOLD_CYCLES - 1)) begin
          state_d               = S_GT_LOCK_WAIT;
          msg_set[MSG_RST_DONE] = 1'b1;
        end
      S_GT_LOCK_WAIT:
        if (&gt_locked) begin
          state_d              = S_RX_ALIGN_WAIT;
          msg_set[MSG_GT_LOCK] = 1'b1;
        end
      S_RX_ALIGN_WAIT:
        if (&rx_aligned) begin
          state_d               = S_PACKET_SEND;
          msg_set[MSG_RX_ALIGN] = 1'b1;
        end
      S_PACKET_SEND:
        if (&tx_done) begin
          state_d              = S_PACKET_RECEIVE;
          msg_set[MSG_TX_DONE] = 1'b1;
        end
      S_PACKET_RECEIVE:
        if (&rx_done) begin
          state_d              = S_IDLE_WAIT;
          msg_set[MSG_RX_DONE] = 1'b1;
        end
      S_IDLE_WAIT:
        if (!(|tx_busy) && !(|rx_busy)) begin
          if (run_count == 8'(NUM_RUNS)) begin
            state_d           = S_DONE;
            msg_set[MSG_DONE] = 1'b1;
          end else begin
            state_d           = S_RESTART;
            msg_set[MSG_IDLE] = 1'b1;
          end
        end
      S_RESTART: begin
        state_d              = S_BUSY_WAIT;
        msg_set[MSG_RESTART] = 1'b1;
      end
      S_BUSY_WAIT:
        if (&tx_busy && &rx_busy) begin
          state_d           = S_PACKET_SEND;
          msg_set[MSG_BUSY] = 1'b1;
        end
      default: ;
    endcase
    // A core failure beats any progress; a timeout only if nothing moved
    if (is_traffic(state_q) && (|tx_fail || |rx_failed)) begin
      state_d = S_FAIL;
      msg_set = '0;
      fail_d  = (|tx_fail) ? FC_TX_FAIL : FC_RX_FAIL;
    end else if (is_timed(state_q) && to_expired &&
                 state_d == state_q) begin
      state_d = S_FAIL;
      fail_d  = FC_TIMEOUT;
    end
  end

  always_ff @(posedge init_clk) begin
    if (clk_reset) begin
      state_q               <= S_RESET_HOLD;
      hold_cnt              <= '0;
      lat_cnt               <= '0;
      sys_reset             <= 1'b1;
      lbus_tx_rx_restart_in <= 1'b0;
      s_axi_pm_tick         <= 1'b0;
      run_count             <= '0;
      msg                   <= '0;
      last_latency          <= '0;
      max_latency           <= '0;
      test_done             <= 1'b0;
      test_pass             <= 1'b0;
      fail_code             <= FC_NONE;
    end else begin
      state_q               <= state_d;
      hold_cnt              <= (state_q == S_RESET_HOLD) ?
                               hold_cnt + 8'd1 : '0;
      sys_reset             <= (state_d == S_RESET_HOLD);
      lbus_tx_rx_restart_in <= (state_d == S_RESTART);
      s_axi_pm_tick         <= rx_exit;
      test_done             <= (state_d == S_DONE) ||
                               (state_d == S_FAIL);
      test_pass             <= (state_d == S_DONE);
      fail_code             <= fail_d;
      msg                   <= msg | msg_set;
      if (lat_clr) begin
        lat_cnt <= '0;
      end else if ((state_q == S_PACKET_SEND ||
                    state_q == S_PACKET_RECEIVE) &&
                   lat_cnt != '1) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (rx_exit) begin
        last_latency <= lat_cnt;
        run_count    <= run_count + 8'd1;
        if (lat_cnt > max_latency) begin
          max_latency <= lat_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_interlaken_test_sequencer.sv
// Directed-random bench for interlaken_test_sequencer with a
// milestone-level reference model kept in the bench.
module tb_interlaken_test_sequencer;

  localparam int NC = 2;
  localparam int NR = 2;
  localparam int RH = 4;
  localparam int TO = 100;
  localparam int LW = 24;

  logic          init_clk = 1'b0;
  logic          clk_reset = 1'b1;
  logic [NC-1:0] gt_locked, rx_aligned, tx_done, tx_busy;
  logic [NC-1:0] rx_done, rx_busy, tx_fail, rx_failed;
  logic          sys_reset, lbus_tx_rx_restart_in, s_axi_pm_tick;
  logic [3:0]    state;
  logic [7:0]    run_count;
  logic [8:0]    msg;
  logic [LW-1:0] last_latency, max_latency;
  logic          test_done, test_pass;
  logic [2:0]    fail_code;

  int total = 0;
  int bad = 0;
  int restarts = 0;
  int lat_q[$];
  int lat_max;

  interlaken_test_sequencer #(
    .NUM_CORES      (NC),
    .NUM_RUNS       (NR),
    .RST_HOLD_CYCLES(RH),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (20),
    .LAT_W          (LW)
  ) dut (
    .init_clk             (init_clk),
    .clk_reset            (clk_reset),
    .gt_locked            (gt_locked),
    .rx_aligned           (rx_aligned),
    .tx_done              (tx_done),
    .tx_busy              (tx_busy),
    .rx_done              (rx_done),
    .rx_busy              (rx_busy),
    .tx_fail              (tx_fail),
    .rx_failed            (rx_failed),
    .sys_reset            (sys_reset),
    .lbus_tx_rx_restart_in(lbus_tx_rx_restart_in),
    .s_axi_pm_tick        (s_axi_pm_tick),
    .state                (state),
    .run_count            (run_count),
    .msg                  (msg),
    .last_latency         (last_latency),
    .max_latency          (max_latency),
    .test_done            (test_done),
    .test_pass            (test_pass),
    .fail_code            (fail_code)
  );

  always #5 init_clk = ~init_clk;

  always @(posedge init_clk)
    if (lbus_tx_rx_restart_in === 1'b1) restarts++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge init_clk);
  endtask

  task automatic wait_state(input logic [3:0] s,
                            input int budget,
                            input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic quiet_inputs();
    gt_locked = '0; rx_aligned = '0;
    tx_done = '0; tx_busy = '0;
    rx_done = '0; rx_busy = '0;
    tx_fail = '0; rx_failed = '0;
  endtask

  task automatic do_reset();
    clk_reset = 1'b1;
    quiet_inputs();
    lat_q.delete();
    lat_max = 0;
    tick(2);
  endtask

  // sys_reset must stay high for RH sampled edges after release
  task automatic release_hold(input string tag);
    int n = 0;
    clk_reset = 1'b0;
    while (sys_reset === 1'b1 && n < 50) begin
      n++;
      tick(1);
    end
    chk({tag, "_hold"}, n, RH);
    chk({tag, "_gtwait"}, state, 1);
  endtask

  function automatic logic [NC-1:0] partial();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  // Returns on the first cycle of PACKET_SEND
  task automatic bring_up(input string tag);
    gt_locked = partial();
    tick($urandom_range(1, 30));
    chk({tag, "_partial_lock"}, state, 1);
    gt_locked = '1;
    tick(1);
    chk({tag, "_align_wait"}, state, 2);
    rx_aligned = partial();
    tick($urandom_range(0, 30));
    rx_aligned = '1;
    tick(1);
    chk({tag, "_send"}, state, 3);
    chk({tag, "_msg"}, msg, 9'h007);
  endtask

  // From cycle 0 of PACKET_SEND, rx_done lands lat cycles later
  task automatic run_packet(input string tag, input int lat,
                            input int idle_busy);
    int tx_at = $urandom_range(0, lat - 2);
    tick(tx_at);
    tx_done = '1;
    tick(1);
    tx_done = '0;
    tick(lat - tx_at - 1);
    rx_done = '1;
    if (idle_busy > 0) tx_busy = partial();
    tick(1);
    rx_done = '0;
    lat_q.push_back(lat);
    if (lat > lat_max) lat_max = lat;
    chk({tag, "_idle"}, state, 5);
    chk({tag, "_tick"}, s_axi_pm_tick, 1'b1);
    chk({tag, "_last"}, last_latency, lat);
    chk({tag, "_max"}, max_latency, lat_max);
    chk({tag, "_runs"}, run_count, lat_q.size());
    tick(idle_busy);
    chk({tag, "_busy_hold"}, state, 5);
    tx_busy = '0;
    tick(1);
  endtask

  initial begin
    int lat, tf, rf, n;
    quiet_inputs();
    lat_max = 0;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_sysrst", sys_reset, 1'b1);
    chk("rst_runs", run_count, 0);
    chk("rst_msg", msg, 0);
    chk("rst_done", {test_done, test_pass}, 0);
    chk("rst_fc", fail_code, 0);
    chk("rst_lat", {last_latency, max_latency}, 0);
    chk("rst_pulses", {lbus_tx_rx_restart_in, s_axi_pm_tick}, 0);

    // Nominal two-run test with latencies 37 then 52
    release_hold("nom");
    chk("nom_msg0", msg, 9'h001);
    bring_up("nom");
    run_packet("nom_r1", 37, $urandom_range(1, 10));
    chk("nom_restart_st", state, 6);
    chk("nom_restart_pulse", lbus_tx_rx_restart_in, 1'b1);
    tx_busy = '1;
    rx_busy = partial();
    tick(1);
    chk("nom_busy_st", state, 7);
    chk("nom_pulse_end", lbus_tx_rx_restart_in, 1'b0);
    tick($urandom_range(0, 20));
    rx_busy = '1;
    tick(1);
    chk("nom_send2", state, 3);
    chk("nom_msg_run1", msg, 9'h0FF);
    tx_busy = '0;
    rx_busy = '0;
    run_packet("nom_r2", 52, 0);
    chk("nom_done_st", state, 8);
    chk("nom_verdict", {test_done, test_pass}, 2'b11);
    chk("nom_msg_all", msg, 9'h1FF);
    chk("nom_fc", fail_code, 0);
    chk("nom_restarts", restarts, 1);
    tick(4);
    chk("nom_terminal", state, 8);

    // Reset in BUSY_WAIT after a random-latency run
    do_reset();
    chk("rst2_state", state, 0);
    chk("rst2_clear", {run_count, msg, test_done}, 0);
    release_hold("mid");
    bring_up("mid");
    lat = $urandom_range(5, 90);
    run_packet("mid_r1", lat, 0);
    tick(1);
    chk("mid_busy", state, 7);
    clk_reset = 1'b1;
    tick(1);
    chk("mid_state", state, 0);
    chk("mid_sysrst", sys_reset, 1'b1);
    chk("mid_runs", run_count, 0);
    chk("mid_msg", msg, 0);
    chk("mid_lat", {last_latency, max_latency}, 0);
    quiet_inputs();
    lat_q.delete();
    lat_max = 0;
    release_hold("mid2");

    // tx_done on the expiry cycle, then tx_fail/rx_failed together
    bring_up("tie");
    tick(TO - 1);
    tx_done = '1;
    tick(1);
    tx_done = '0;
    chk("tie_state", state, 4);
    chk("tie_fc", fail_code, 0);
    tick($urandom_range(0, 20));
    tx_fail = 2'b01;
    rx_failed = 2'b10;
    tick(1);
    chk("prec_state", state, 9);
    chk("prec_fc", fail_code, 2);
    chk("prec_verdict", {test_done, test_pass}, 2'b10);
    quiet_inputs();
    tick(5);
    chk("prec_terminal", state, 9);

    // Only core 0 locks: timeout after TO cycles
    do_reset();
    release_hold("to");
    gt_locked = 2'b01;
    n = 0;
    while (state === 4'd1 && n < 300) begin
      n++;
      tick(1);
    end
    chk("to_cycles", n, TO);
    chk("to_state", state, 9);
    chk("to_fc", fail_code, 1);
    chk("to_verdict", {test_done, test_pass}, 2'b10);

    // Random failure patterns during PACKET_SEND
    for (int i = 0; i < 3; i++) begin
      do_reset();
      release_hold("rf");
      bring_up("rf");
      tf = $urandom_range(0, 3);
      rf = $urandom_range(0, 3);
      if (tf == 0 && rf == 0) rf = 2;
      tx_fail = tf[NC-1:0];
      rx_failed = rf[NC-1:0];
      tick(1);
      chk("rf_state", state, 9);
      chk("rf_fc", fail_code, (tf != 0) ? 2 : 3);
    end

    wait_state(4'd9, 5, "final_state");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
